// File: rtl/sdram_frame_writer.sv
// Packs an 8-bit pixel stream into 16-bit words and writes one full frame to SDRAM
// through an Avalon-style write master. Optional running checksum: SDRAM_FRAME_WRITER_CHECKSUM_EN.
`timescale 1ns/1ps
module sdram_frame_writer #(
  parameter int LINES = 768
) (
  input  logic        clock,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [5:0]  iFRAME_ID,
  input  logic        iABORT,
  input  logic [7:0]  iPIX_DATA,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  output logic        oWR_EN,
  output logic [24:0] oWR_ADDR,
  output logic [15:0] oWR_DATA,
  input  logic        iWAIT_REQUEST,
  output logic        oBUSY,
  output logic        oDONE,
  output logic [15:0] oCHECKSUM
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_HI = 3'd1,
    GET_LO = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } stateT;

  localparam logic [9:0] LAST_LINE = 10'(LINES - 1);

  stateT       stateReg;
  stateT       stateNext;
  logic [5:0]  frameReg;
  logic [9:0]  lineReg;
  logic [8:0]  wordReg;
  logic [15:0] dataReg;
  logic        abortReg;

  logic startAccepted;
  logic writeAccepted;
  logic lastWord;
  logic abortNow;

  assign startAccepted = (stateReg == IDLE) && iSTART;
  assign writeAccepted = (stateReg == WRITE) && !iWAIT_REQUEST;
  assign lastWord      = (lineReg == LAST_LINE) && (wordReg == 9'd511);
  // An abort seen earlier in a stalled WRITE must still take effect on acceptance.
  assign abortNow      = abortReg || iABORT;

  always_ff @(posedge clock or posedge iRST) begin
    if (iRST) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (iSTART) stateNext = GET_HI;
      end
      GET_HI: begin
        if (iABORT)          stateNext = IDLE;
        else if (iPIX_VALID) stateNext = GET_LO;
      end
      GET_LO: begin
        if (iABORT)          stateNext = IDLE;
        else if (iPIX_VALID) stateNext = WRITE;
      end
      WRITE: begin
        if (!iWAIT_REQUEST) begin
          if (abortNow)      stateNext = IDLE;
          else if (lastWord) stateNext = DONE;
          else               stateNext = GET_HI;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge iRST) begin
    if (iRST) begin
      frameReg <= '0;
      lineReg  <= '0;
      wordReg  <= '0;
      dataReg  <= '0;
      abortReg <= 1'b0;
    end else begin
      if (startAccepted) begin
        frameReg <= iFRAME_ID;
        lineReg  <= '0;
        wordReg  <= '0;
      end
      if ((stateReg == GET_HI) && iPIX_VALID) dataReg[15:8] <= iPIX_DATA;
      if ((stateReg == GET_LO) && iPIX_VALID) dataReg[7:0]  <= iPIX_DATA;
      if (writeAccepted) begin
        wordReg <= wordReg + 9'd1;
        if (wordReg == 9'd511) lineReg <= lineReg + 10'd1;
      end
      if (stateReg == WRITE) begin
        if (writeAccepted) abortReg <= 1'b0;
        else if (iABORT)   abortReg <= 1'b1;
      end else begin
        abortReg <= 1'b0;
      end
    end
  end

  assign oPIX_READY = (stateReg == GET_HI) || (stateReg == GET_LO);
  assign oWR_EN     = (stateReg == WRITE);
  assign oWR_ADDR   = {frameReg, lineReg, wordReg};
  assign oWR_DATA   = dataReg;
  assign oBUSY      = (stateReg != IDLE);
  assign oDONE      = (stateReg == DONE);

`ifdef SDRAM_FRAME_WRITER_CHECKSUM_EN
  logic [15:0] checksumReg;

  always_ff @(posedge clock or posedge iRST) begin
    if (iRST) begin
      checksumReg <= '0;
    end else if (startAccepted) begin
      checksumReg <= '0;
    end else if (writeAccepted) begin
      checksumReg <= checksumReg + dataReg;
    end
  end

  assign oCHECKSUM = checksumReg;
`else
  assign oCHECKSUM = '0;
`endif

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Scoreboard bench for sdram_frame_writer on a 4-line frame: expected writes are queued
// from the byte stream, a negedge monitor pops and compares every accepted write.
`timescale 1ns/1ps
module tb_sdram_frame_writer;

  localparam int LINES_TB = 4;
  localparam int WORDS    = 512 * LINES_TB;
  localparam int BYTES    = 2 * WORDS;

  logic        clock = 1'b0;
  logic        iRST;
  logic        iSTART;
  logic [5:0]  iFRAME_ID;
  logic        iABORT;
  logic [7:0]  iPIX_DATA;
  logic        iPIX_VALID;
  logic        oPIX_READY;
  logic        oWR_EN;
  logic [24:0] oWR_ADDR;
  logic [15:0] oWR_DATA;
  logic        iWAIT_REQUEST;
  logic        oBUSY;
  logic        oDONE;
  logic [15:0] oCHECKSUM;

  sdram_frame_writer #(.LINES(LINES_TB)) dut (
    .clock         (clock),
    .iRST          (iRST),
    .iSTART        (iSTART),
    .iFRAME_ID     (iFRAME_ID),
    .iABORT        (iABORT),
    .iPIX_DATA     (iPIX_DATA),
    .iPIX_VALID    (iPIX_VALID),
    .oPIX_READY    (oPIX_READY),
    .oWR_EN        (oWR_EN),
    .oWR_ADDR      (oWR_ADDR),
    .oWR_DATA      (oWR_DATA),
    .iWAIT_REQUEST (iWAIT_REQUEST),
    .oBUSY         (oBUSY),
    .oDONE         (oDONE),
    .oCHECKSUM     (oCHECKSUM)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [7:0]  srcBytes [0:BYTES-1];
  logic [24:0] expAddrQ [$];
  logic [15:0] expDataQ [$];
  logic [24:0] logAddr  [$];
  logic [15:0] logData  [$];
  logic [15:0] expCk = 16'h0;
  int          wrCount   = 0;
  int          doneCount = 0;

  logic        holdValid = 1'b0;
  logic [24:0] holdAddr;
  logic [15:0] holdData;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: word k of the frame goes to {id, k/512, k%512} with data {byte 2k, byte 2k+1}.
  task automatic pushFrame(input logic [5:0] id);
    logic [15:0] sum;
    logic [15:0] w;
    sum = 16'h0;
    for (int k = 0; k < WORDS; k++) begin
      w = {srcBytes[2*k], srcBytes[2*k+1]};
      expAddrQ.push_back(25'(id) * 25'd524288 + 25'(k / 512) * 25'd512 + 25'(k % 512));
      expDataQ.push_back(w);
      sum = sum + w;
    end
`ifdef SDRAM_FRAME_WRITER_CHECKSUM_EN
    expCk = sum;
`else
    expCk = 16'h0;
`endif
  endtask

  always @(negedge clock) begin
    if (oWR_EN) begin
      if (holdValid) begin
        checkEq("stall_addr_stable", oWR_ADDR, holdAddr);
        checkEq("stall_data_stable", oWR_DATA, holdData);
      end
      if (!iWAIT_REQUEST) begin
        holdValid = 1'b0;
        wrCount++;
        logAddr.push_back(oWR_ADDR);
        logData.push_back(oWR_DATA);
        if (expAddrQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=0x%0h required=none", oWR_ADDR);
        end else begin
          checkEq("write_addr", oWR_ADDR, expAddrQ.pop_front());
          checkEq("write_data", oWR_DATA, expDataQ.pop_front());
        end
      end else begin
        holdValid = 1'b1;
        holdAddr  = oWR_ADDR;
        holdData  = oWR_DATA;
      end
    end else begin
      holdValid = 1'b0;
    end
    if (oDONE) begin
      doneCount++;
      checkEq("checksum_at_done", oCHECKSUM, expCk);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic startFrame(input logic [5:0] id);
    iSTART    = 1'b1;
    iFRAME_ID = id;
    tick();
    iSTART    = 1'b0;
    iFRAME_ID = 6'($urandom);
    checkEq("ready_latency", oPIX_READY, 1);
    checkEq("busy_after_start", oBUSY, 1);
  endtask

  // Feeds the whole source frame until every expected write has been seen.
  task automatic stream(input bit pixRand, input bit wrRand, input bit startNoise, input int budget);
    int idx = 0;
    int cyc = 0;
    while ((idx < BYTES || expAddrQ.size() != 0) && cyc < budget) begin
      iPIX_VALID    = (idx < BYTES) && (!pixRand || ($urandom_range(1, 0) == 1));
      iPIX_DATA     = (idx < BYTES) ? srcBytes[idx] : 8'h00;
      iWAIT_REQUEST = wrRand ? 1'($urandom_range(1, 0)) : 1'b0;
      if (startNoise) begin
        iSTART    = 1'($urandom_range(1, 0));
        iFRAME_ID = 6'($urandom);
      end
      @(negedge clock);
      if (iPIX_VALID && oPIX_READY) idx++;
      tick();
      cyc++;
    end
    iPIX_VALID    = 1'b0;
    iWAIT_REQUEST = 1'b0;
    iSTART        = 1'b0;
    checkEq("bytes_consumed", idx, BYTES);
    checkEq("writes_outstanding", expAddrQ.size(), 0);
    expAddrQ.delete();
    expDataQ.delete();
  endtask

  initial begin
    int d0;
    int w0;
    iRST = 1'b1; iSTART = 1'b0; iFRAME_ID = 6'h0; iABORT = 1'b0;
    iPIX_DATA = 8'h00; iPIX_VALID = 1'b0; iWAIT_REQUEST = 1'b0;
    repeat (3) tick();
    checkEq("reset_ready", oPIX_READY, 0);
    checkEq("reset_wr_en", oWR_EN, 0);
    checkEq("reset_addr", oWR_ADDR, 0);
    checkEq("reset_data", oWR_DATA, 0);
    checkEq("reset_busy", oBUSY, 0);
    checkEq("reset_done", oDONE, 0);
    checkEq("reset_checksum", oCHECKSUM, 0);
    iRST = 1'b0;
    tick();

    // Full frame, counting bytes, no stalls.
    for (int k = 0; k < BYTES; k++) srcBytes[k] = 8'(k % 256);
    logAddr.delete(); logData.delete();
    d0 = doneCount;
    pushFrame(6'd5);
    startFrame(6'd5);
    stream(1'b0, 1'b0, 1'b0, 20000);
    repeat (3) tick();
    checkEq("full_done_pulses", doneCount - d0, 1);
    checkEq("full_busy_after", oBUSY, 0);
    checkEq("full_write_count", logAddr.size(), WORDS);
    if (logAddr.size() == WORDS) begin
      checkEq("first_addr", logAddr[0], 25'h280000);
      checkEq("first_data", logData[0], 16'h0001);
      checkEq("line_end_addr", logAddr[511], 25'h2801FF);
      checkEq("line_wrap_addr", logAddr[512], 25'h280200);
      checkEq("last_addr", logAddr[WORDS-1], 25'h2807FF);
      checkEq("last_data", logData[WORDS-1], 16'hFEFF);
    end
    checkEq("checksum_hold", oCHECKSUM, expCk);
    $display("frame id=5 no stalls: writes=%0d done=%0d", logAddr.size(), doneCount - d0);

    // Same frame with random stalls on both sides.
    d0 = doneCount;
    w0 = wrCount;
    pushFrame(6'd5);
    startFrame(6'd5);
    stream(1'b1, 1'b1, 1'b0, 40000);
    repeat (3) tick();
    checkEq("stall_done_pulses", doneCount - d0, 1);
    checkEq("stall_write_count", wrCount - w0, WORDS);
    checkEq("stall_busy_after", oBUSY, 0);
    $display("frame id=5 random stalls: writes=%0d", wrCount - w0);

    // Abort in GET_LO after one byte.
    d0 = doneCount;
    w0 = wrCount;
    startFrame(6'd9);
    iPIX_VALID = 1'b1; iPIX_DATA = 8'h77;
    tick();
    iPIX_VALID = 1'b0; iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
    checkEq("abort_lo_busy", oBUSY, 0);
    checkEq("abort_lo_ready", oPIX_READY, 0);
    repeat (5) tick();
    checkEq("abort_lo_writes", wrCount - w0, 0);
    checkEq("abort_lo_done", doneCount - d0, 0);
    $display("abort in GET_LO: writes=%0d", wrCount - w0);

    // Abort in WRITE while stalled for three cycles.
    d0 = doneCount;
    w0 = wrCount;
    expAddrQ.push_back(25'd12 * 25'd524288);
    expDataQ.push_back(16'h3CA5);
    startFrame(6'd12);
    iWAIT_REQUEST = 1'b1;
    iPIX_VALID = 1'b1; iPIX_DATA = 8'h3C;
    tick();
    iPIX_DATA = 8'hA5;
    tick();
    iPIX_VALID = 1'b0; iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
    tick();
    tick();
    checkEq("abort_wr_still_busy", oBUSY, 1);
    iWAIT_REQUEST = 1'b0;
    tick();
    checkEq("abort_wr_idle", oBUSY, 0);
    repeat (5) tick();
    checkEq("abort_wr_writes", wrCount - w0, 1);
    checkEq("abort_wr_done", doneCount - d0, 0);
    checkEq("abort_wr_queue", expAddrQ.size(), 0);
    expAddrQ.delete(); expDataQ.delete();
    $display("abort in WRITE: writes=%0d", wrCount - w0);

    // Reset while a write is stalled, then a fresh frame with start noise.
    startFrame(6'd20);
    iWAIT_REQUEST = 1'b1;
    iPIX_VALID = 1'b1; iPIX_DATA = 8'h11;
    tick();
    iPIX_DATA = 8'h22;
    tick();
    iPIX_VALID = 1'b0;
    checkEq("pre_reset_wr_en", oWR_EN, 1);
    iRST = 1'b1;
    #1;
    checkEq("async_rst_wr_en", oWR_EN, 0);
    checkEq("async_rst_addr", oWR_ADDR, 0);
    checkEq("async_rst_data", oWR_DATA, 0);
    checkEq("async_rst_busy", oBUSY, 0);
    checkEq("async_rst_ready", oPIX_READY, 0);
    tick();
    iRST = 1'b0;
    iWAIT_REQUEST = 1'b0;
    tick();
    for (int k = 0; k < BYTES; k++) srcBytes[k] = 8'($urandom);
    d0 = doneCount;
    w0 = wrCount;
    pushFrame(6'd21);
    startFrame(6'd21);
    stream(1'b1, 1'b1, 1'b1, 40000);
    repeat (3) tick();
    checkEq("post_rst_done_pulses", doneCount - d0, 1);
    checkEq("post_rst_write_count", wrCount - w0, WORDS);
    checkEq("post_rst_busy_after", oBUSY, 0);
    $display("frame id=21 after reset with start noise: writes=%0d", wrCount - w0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
